tile_line_fetcher: RTL
======================

Name: tile_line_fetcher

Overview:
- Sequences the 16x16 terrain tile sprite ROMs (brick, steel, water, …) to fill one scanline of the 208-pixel playfield line buffer.
- On each start it walks the 13 tile-map entries of the current tile row and selects the matching ROM row. It then serialises the 16 four-bit palette indices of that row into the line buffer, one pixel per cycle.
- Sits between the VGA timing generator (start at hblank) and the line buffer read by the pixel output stage.

Parameters:
- MAP_W, 13, tiles per map row.
- MAP_H, 13, tile rows in the map; valid line_y is 0..MAP_H*16-1.
- PIX_W, 4, palette index width.
- TID_W, 3, tile id width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: render line line_y
- abort  in  1  synchronous cancel of the current line
- line_y  in  8  playfield line, sampled only when start is accepted
- map_rd_en  out  1  tile map read strobe
- map_addr  out  8  tile_row*MAP_W + col
- map_data  in  TID_W  tile id, valid the cycle after map_rd_en
- rom_tile_id  out  TID_W  tile id to the external ROM mux
- rom_row  out  4  pixel row within tile (line_y[3:0])
- rom_row_data  in  16*PIX_W  combinational row from ROM mux; pixel c at bits [c*4+3:c*4]
- lb_wr_en  out  1  line buffer write strobe
- lb_addr  out  8  pixel x, 0..207
- lb_wr_data  out  PIX_W  palette index
- busy  out  1  line in progress
- done  out  1  one-cycle pulse, line complete
- range_err  out  1  one-cycle pulse, start with line_y >= MAP_H*16

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal col/pixel counters 0. Reset mid-line aborts the line with no done and leaves the line buffer partially written.
- FSM states: IDLE, MAP_RD, MAP_WAIT, EMIT, DONE.
- IDLE:
  - On start with line_y < 208: latch line_y, col=0, go to MAP_RD.
  - On start with line_y >= 208: range_err=1 for the next cycle, no writes, no done; stay IDLE.
- MAP_RD (1 cycle): map_rd_en=1, map_addr=row*13+col, computed as row*8+row*4+row; maximum 168.
- MAP_WAIT (1 cycle): capture map_data into the tile id register, px=0.
- EMIT (16 cycles):
  - lb_wr_en=1, lb_addr=col*16+px, lb_wr_data=rom_row_data[px].
  - Tile id 0 (EMPTY) forces lb_wr_data=0 regardless of ROM.
  - At px=15: if col=12 go to DONE, else col+=1 and go to MAP_RD.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in every state except IDLE, including the DONE cycle.
- Timing, with start sampled at edge 0:
  - map_rd_en in cycle 1.
  - Tile t pixels written in cycles 18t+3 .. 18t+18; last write in cycle 234.
  - done in cycle 235; busy low from cycle 236.
- rom_tile_id and rom_row are stable for the whole EMIT window of a tile.
- start while busy is ignored; the line in progress is unaffected.
- abort in any non-IDLE state returns to IDLE on the next edge. No done is raised, lb_wr_en is low from that edge, and busy drops.
- abort has priority over start in the same cycle.
- In IDLE, abort is a no-op.

Decomposition:
- Shared package tank_gfx_pkg holds:
  - constants TILE_PX=16, MAP_W=13, MAP_H=13, PIX_W=4, LINE_W=208;
  - enum tile_id_e: EMPTY=0, BRICK=1, STEEL=2, WATER=3, FOREST=4, ICE=5, BASE=6;
  - the FSM state enum.
- The ROM row selection is a separate combinational sub-module, tile_rom_mux. It instantiates the tile sprite ROMs and indexes by rom_tile_id/rom_row. It lives outside this block and is instantiated alongside it in the renderer top.

Test Plan:
- Map row 0 all STEEL (id 2), start with line_y=2 -> 208 writes.
  - Pixel 0 value 4 is written at cycle 3.
  - lb_addr runs 0..207 contiguously within tiles.
  - Each tile writes pattern 4,4,5,5,5,5,1,1,4,4,5,5,5,5,1,1.
  - done at cycle 235.
- Map row 3 mixed ids, e.g. col 0 = EMPTY, col 5 = BRICK; start with line_y=55.
  - map_addr sequence is 39..51.
  - rom_row=7 throughout.
  - x 0..15 written as 0.
  - x 80..95 carry BRICK row 7.
- Start with line_y=208 -> range_err pulse the next cycle; no map_rd_en, no lb_wr_en, no done.
- Second start at cycle 100 of a line -> ignored; done still at cycle 235; exactly 208 writes.
- abort at cycle 50 -> busy low and lb_wr_en low from cycle 51; no done. A fresh start at cycle 60 completes normally.
- rst_n low at cycle 120 -> all outputs 0 immediately (async). After release, a start renders the full line with correct timing.

Source files
------------

// File: rtl/tank_gfx_pkg.sv
// Shared tile-graphics definitions: playfield geometry, tile ids and fetcher FSM states.
package tank_gfx_pkg;

    localparam int TILE_PX = 16;
    localparam int MAP_W   = 13;
    localparam int MAP_H   = 13;
    localparam int PIX_W   = 4;
    localparam int LINE_W  = MAP_W * TILE_PX;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        BRICK  = 3'd1,
        STEEL  = 3'd2,
        WATER  = 3'd3,
        FOREST = 3'd4,
        ICE    = 3'd5,
        BASE   = 3'd6
    } tile_id_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAP_RD   = 3'd1,
        MAP_WAIT = 3'd2,
        EMIT     = 3'd3,
        DONE     = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/tile_line_fetcher.sv
// Walks one tile-map row and streams the selected ROM row of each tile into the
// playfield line buffer, one palette index per cycle.
module tile_line_fetcher
    import tank_gfx_pkg::*;
#(
    parameter int MAP_W = 13,
    parameter int MAP_H = 13,
    parameter int PIX_W = 4,
    parameter int TID_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [7:0]            line_y,
    output logic                  map_rd_en,
    output logic [7:0]            map_addr,
    input  logic [TID_W-1:0]      map_data,
    output logic [TID_W-1:0]      rom_tile_id,
    output logic [3:0]            rom_row,
    input  logic [16*PIX_W-1:0]   rom_row_data,
    output logic                  lb_wr_en,
    output logic [7:0]            lb_addr,
    output logic [PIX_W-1:0]      lb_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err
);

    localparam logic [7:0] Y_LIM    = 8'(MAP_H * TILE_PX);
    localparam logic [3:0] LAST_COL = 4'(MAP_W - 1);

    fetch_state_e     state, state_nxt;
    logic [3:0]       col, px, row;
    logic [7:0]       y_q;
    logic [TID_W-1:0] tid;
    logic [PIX_W-1:0] pix;
    logic             start_ok, start_bad;

    assign row       = y_q[7:4];
    assign start_ok  = start && !abort && (line_y <  Y_LIM);
    assign start_bad = start && !abort && (line_y >= Y_LIM);

    always_comb begin
        state_nxt = state;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (start_ok) state_nxt = MAP_RD;
                MAP_RD:   state_nxt = MAP_WAIT;
                MAP_WAIT: state_nxt = EMIT;
                EMIT:     if (px == 4'd15) state_nxt = (col == LAST_COL) ? DONE : MAP_RD;
                DONE:     state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            px        <= '0;
            y_q       <= '0;
            tid       <= '0;
            range_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            range_err <= (state == IDLE) && start_bad;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        y_q <= line_y;
                        col <= '0;
                        px  <= '0;
                    end
                end
                MAP_WAIT: begin
                    tid <= map_data;
                    px  <= '0;
                end
                EMIT: begin
                    px <= px + 4'd1;
                    if (px == 4'd15 && col != LAST_COL) col <= col + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // row*13 built from shifts so no multiplier is inferred
    assign map_addr = {1'b0, row, 3'b000} + {2'b00, row, 2'b00} + {4'b0000, row} + {4'b0000, col};
    assign map_rd_en = (state == MAP_RD);

    assign pix        = rom_row_data[px*PIX_W +: PIX_W];
    assign lb_wr_en   = (state == EMIT);
    assign lb_addr    = {col, px};
    assign lb_wr_data = (lb_wr_en && tid != TID_W'(EMPTY)) ? pix : '0;

    assign rom_tile_id = tid;
    assign rom_row     = y_q[3:0];
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule
